// File: rtl/wave_capture.sv
// -----------------------------------------------------------------------------
// wave_capture
//   Records an incoming sample stream into a capture RAM under control of a
//   queue of commands. Each command gives a start address, a length and a
//   decimation factor. A host reads captured words back through an
//   auto-incrementing read port, which may be used while a capture is running.
//
// Ports
//   clk, rst_n      single clock (rising edge), asynchronous active-low reset
//   din, din_v      input sample stream
//   wcmd, wcmd_v    command push: [23:16] decim, [15:8] len, [7:0] start addr
//   go              start executing the queued command list
//   raddr, raddr_v  load the readback pointer
//   rd_req          read RAM[rptr]; rdata/rdata_v valid next cycle, rptr++
//   rdata, rdata_v  readback data (rdata holds while rdata_v=0)
//   done            one-cycle pulse when the command list completes
//   status          [0] busy [1] done_sticky [2] fifo_empty [3] fifo_full
//                   [4] cmd_overflow [15:8] fifo count (low 8 bits)
// -----------------------------------------------------------------------------
module wave_capture #(
  parameter int CAP_RAM_DEPTH  = 256,
  parameter int CMD_FIFO_DEPTH = 16,
  parameter int AWIDTH         = 8,
  parameter int DWIDTH         = 16,
  parameter int CWIDTH         = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DWIDTH-1:0] din,
  input  logic              din_v,
  input  logic [CWIDTH-1:0] wcmd,
  input  logic              wcmd_v,
  input  logic              go,
  input  logic [AWIDTH-1:0] raddr,
  input  logic              raddr_v,
  input  logic              rd_req,
  output logic [DWIDTH-1:0] rdata,
  output logic              rdata_v,
  output logic              done,
  output logic [15:0]       status
);

  localparam int FAW  = $clog2(CMD_FIFO_DEPTH);
  localparam int CNTW = FAW + 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_CAPTURE, S_DONE} state_e;

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  logic [CWIDTH-1:0] fifo_mem [CMD_FIFO_DEPTH];
  logic [FAW-1:0]    fifo_wr_q, fifo_rd_q;
  logic [CNTW-1:0]   fifo_cnt_q, fifo_cnt_d;
  logic              fifo_empty, fifo_full, fifo_push, fifo_pop;
  logic              ovf_q;
  logic [CWIDTH-1:0] fifo_head;

  state_e            state_q;
  logic              go_start;

  assign fifo_empty = (fifo_cnt_q == '0);
  assign fifo_full  = (fifo_cnt_q == CNTW'(CMD_FIFO_DEPTH));
  assign fifo_push  = wcmd_v && !fifo_full;
  // FETCH is only ever entered with a command waiting, so the pop is unguarded.
  assign fifo_pop   = (state_q == S_FETCH);
  assign fifo_head  = fifo_mem[fifo_rd_q];
  assign go_start   = (state_q == S_IDLE) && go && !fifo_empty;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    if (fifo_push && !fifo_pop)      fifo_cnt_d = fifo_cnt_q + 1'b1;
    else if (!fifo_push && fifo_pop) fifo_cnt_d = fifo_cnt_q - 1'b1;
  end

  // NOTE: storage arrays sit in clock-only blocks without reset; clearing a
  // RAM costs a mux per bit and its contents are defined by writes anyway.
  // Sequential state always uses non-blocking assignments.
  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem[fifo_wr_q] <= wcmd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_wr_q  <= '0;
      fifo_rd_q  <= '0;
      fifo_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      if (fifo_push) fifo_wr_q <= fifo_wr_q + 1'b1;
      if (fifo_pop)  fifo_rd_q <= fifo_rd_q + 1'b1;
      fifo_cnt_q <= fifo_cnt_d;
      // A dropped push in the same cycle as go wins over the clear.
      if (wcmd_v && fifo_full) ovf_q <= 1'b1;
      else if (go_start)       ovf_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Capture FSM
  // ---------------------------------------------------------------------------
  logic [AWIDTH-1:0] wptr_q;
  logic [7:0]        remain_q, decim_q, dcnt_q, dcnt_nxt;
  logic              done_q, done_sticky_q;
  logic              cap_take, more_cmds;

  assign cap_take  = (state_q == S_CAPTURE) && din_v && (dcnt_q == '0);
  // Looks at the post-pop/post-push count so a command pushed this cycle counts.
  assign more_cmds = (fifo_cnt_d != '0);

  // Decimation counter runs modulo max(decim,1) over valid samples.
  always_comb begin
    dcnt_nxt = dcnt_q + 8'd1;
    if (decim_q <= 8'd1 || dcnt_q == decim_q - 8'd1) dcnt_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      wptr_q        <= '0;
      remain_q      <= '0;
      decim_q       <= '0;
      dcnt_q        <= '0;
      done_q        <= 1'b0;
      done_sticky_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (go) begin
            if (!fifo_empty) begin
              state_q       <= S_FETCH;
              done_sticky_q <= 1'b0;
            end else begin
              state_q       <= S_DONE;
              done_q        <= 1'b1;
              done_sticky_q <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          wptr_q   <= fifo_head[AWIDTH-1:0];
          remain_q <= fifo_head[15:8];
          decim_q  <= fifo_head[23:16];
          dcnt_q   <= '0;
          if (fifo_head[15:8] != 8'd0) begin
            state_q <= S_CAPTURE;
          end else if (!more_cmds) begin
            state_q       <= S_DONE;
            done_q        <= 1'b1;
            done_sticky_q <= 1'b1;
          end
        end
        S_CAPTURE: begin
          if (din_v) begin
            dcnt_q <= dcnt_nxt;
            if (dcnt_q == '0) begin
              wptr_q   <= wptr_q + 1'b1;
              remain_q <= remain_q - 8'd1;
              if (remain_q == 8'd1) begin
                if (more_cmds) begin
                  state_q <= S_FETCH;
                end else begin
                  state_q       <= S_DONE;
                  done_q        <= 1'b1;
                  done_sticky_q <= 1'b1;
                end
              end
            end
          end
        end
        S_DONE: begin
          // Held go parks here so it cannot retrigger the list.
          if (!go) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Capture RAM and readback port
  // ---------------------------------------------------------------------------
  logic [DWIDTH-1:0] cap_mem [CAP_RAM_DEPTH];
  logic [AWIDTH-1:0] rptr_q, rd_addr;
  logic [DWIDTH-1:0] rdata_q;
  logic              rdata_v_q;

  assign rd_addr = raddr_v ? raddr : rptr_q;

  always_ff @(posedge clk) begin
    if (cap_take) cap_mem[wptr_q] <= din;
  end

  // Same-address read and write return the old word: the read samples the
  // array before the write's non-blocking update lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr_q    <= '0;
      rdata_q   <= '0;
      rdata_v_q <= 1'b0;
    end else begin
      rdata_v_q <= rd_req;
      if (rd_req) begin
        rdata_q <= cap_mem[rd_addr];
        rptr_q  <= rd_addr + 1'b1;
      end else if (raddr_v) begin
        rptr_q <= raddr;
      end
    end
  end

  assign rdata   = rdata_q;
  assign rdata_v = rdata_v_q;
  assign done    = done_q;
  assign status  = {8'(fifo_cnt_q), 3'b000, ovf_q, fifo_full, fifo_empty,
                    done_sticky_q, (state_q == S_FETCH) || (state_q == S_CAPTURE)};

endmodule

// File: tb/tb_wave_capture.sv
// -----------------------------------------------------------------------------
// tb_wave_capture
//   Directed bench for wave_capture: single commands, decimation, address
//   wrap, FIFO overflow, a 16-command list with gapped input, asynchronous
//   reset mid-list and go with an empty queue. Readback of the short captures
//   is table-driven; expected words are hand-computed from the stimulus.
// -----------------------------------------------------------------------------
module tb_wave_capture;

  logic        clk, rst_n;
  logic [15:0] din;
  logic        din_v;
  logic [23:0] wcmd;
  logic        wcmd_v, go;
  logic [7:0]  raddr;
  logic        raddr_v, rd_req;
  logic [15:0] rdata;
  logic        rdata_v, done;
  logic [15:0] status;

  wave_capture dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_v(din_v),
    .wcmd(wcmd), .wcmd_v(wcmd_v), .go(go),
    .raddr(raddr), .raddr_v(raddr_v), .rd_req(rd_req),
    .rdata(rdata), .rdata_v(rdata_v), .done(done), .status(status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    bit          ld;
    bit          rd;
    logic [7:0]  addr;
    logic [15:0] data;
    bit          v;
  } rb_vec_t;

  rb_vec_t tbl[$];
  int      s_start[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [23:0] c);
    wcmd   = c;
    wcmd_v = 1'b1;
    step();
    wcmd_v = 1'b0;
  endtask

  function automatic void add(input bit ld, input bit rd, input logic [7:0] a,
                              input logic [15:0] d, input bit v);
    rb_vec_t r;
    r.ld = ld; r.rd = rd; r.addr = a; r.data = d; r.v = v;
    tbl.push_back(r);
  endfunction

  // One queued command, din=base+c with din_v every cycle. Edge c=0 takes go,
  // c=1 is FETCH, samples are captured from edge c=2 on.
  task automatic run_single(input string name, input logic [23:0] cmd, input int base,
                            input int go_cycles, input int total, input int done_exp,
                            input int rd_at, input logic [15:0] exp0, input logic [15:0] exp1);
    int dones, done_at;
    dones = 0; done_at = -1;
    push(cmd);
    for (int c = 0; c < total; c++) begin
      din     = 16'(base + c);
      din_v   = 1'b1;
      go      = (c < go_cycles);
      raddr   = 8'h00;
      raddr_v = (c == rd_at);
      rd_req  = (rd_at >= 0) && (c == rd_at || c == rd_at + 1);
      step();
      if (done) begin dones++; done_at = c; end
      if (c == 3) check({name, "_busy_status"}, status, 16'h0005);
      if (rd_at >= 0 && c == rd_at)     check({name, "_rw_same0"}, rdata, exp0);
      if (rd_at >= 0 && c == rd_at + 1) check({name, "_rw_same1"}, rdata, exp1);
    end
    din_v = 1'b0; go = 1'b0; raddr_v = 1'b0; rd_req = 1'b0;
    step();
    check({name, "_done_count"}, dones, 1);
    check({name, "_done_cycle"}, done_at, done_exp);
    check({name, "_end_status"}, status, 16'h0006);
  endtask

  // Command list with din_v on even cycles; din carries the valid-sample index.
  task automatic run_multi(input string name, input int stop_n, output int dones);
    int n;
    bit finished;
    n = 0; dones = 0; finished = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      din_v = (c % 2 == 0);
      din   = din_v ? 16'(n) : 16'hDEAD;
      go    = (c < 10);
      step();
      if (din_v) n++;
      if (c == 0) check({name, "_status_after_go"}, status, 16'h1009);
      if (done) dones++;
      if ((stop_n >= 0 && n == stop_n) || (stop_n < 0 && dones > 0)) begin
        finished = 1'b1;
        break;
      end
    end
    din_v = 1'b0; go = 1'b0;
    check({name, "_finished_in_budget"}, finished, 1);
  endtask

  task automatic read_regions(input string name, input int nreg);
    for (int j = 0; j < nreg; j++) begin
      for (int i = 0; i < 10; i++) begin
        raddr   = 8'(j * 16);
        raddr_v = (i == 0);
        rd_req  = 1'b1;
        step();
        check($sformatf("%s_r%0d_%0d", name, j, i), rdata, 16'(s_start[j] + i * (j + 1)));
      end
    end
    raddr_v = 1'b0; rd_req = 1'b0;
  endtask

  initial begin
    int dones;
    rst_n = 1'b0; din = '0; din_v = 1'b0; wcmd = '0; wcmd_v = 1'b0;
    go = 1'b0; raddr = '0; raddr_v = 1'b0; rd_req = 1'b0;

    // First stored sample of command j is valid-sample index s_start[j]; a
    // command with decim d and len 10 consumes 9d+1 samples, and the next
    // command starts at the following valid sample.
    s_start[0] = 1;
    for (int j = 0; j < 15; j++) s_start[j + 1] = s_start[j] + 9 * (j + 1) + 1;

    // Readback vectors for the short captures below.
    add(1, 1, 8'h10, 16'd102, 1);
    for (int i = 1; i < 8; i++) add(0, 1, 8'h00, 16'(102 + i), 1);
    add(1, 1, 8'h20, 16'd202, 1);
    add(0, 1, 8'h00, 16'd205, 1);
    add(0, 1, 8'h00, 16'd208, 1);
    add(0, 1, 8'h00, 16'd211, 1);
    add(1, 0, 8'h04, 16'd211, 0);   // load only: data holds, no valid
    add(0, 1, 8'h00, 16'd406, 1);   // RAM[0x04] untouched by the wrap run
    add(0, 1, 8'h00, 16'd407, 1);
    add(1, 1, 8'hFE, 16'd304, 1);
    add(0, 1, 8'h00, 16'd305, 1);
    add(0, 1, 8'h00, 16'd306, 1);   // wrapped to 0x00
    add(0, 1, 8'h00, 16'd307, 1);
    add(0, 0, 8'h00, 16'd307, 0);

    // Reset state
    repeat (2) step();
    check("rst_status", status, 16'h0004);
    check("rst_rdata", rdata, 16'h0000);
    check("rst_rdata_v", rdata_v, 0);
    check("rst_done", done, 0);
    #4 rst_n = 1'b1;
    step();

    // Single command, decimation, prefill of 0x00..0x07, then a wrapping
    // capture with reads hitting the addresses being written.
    run_single("single", 24'h000810, 100, 1, 14, 9, -1, 16'h0, 16'h0);
    run_single("decim", 24'h030420, 200, 16, 20, 11, -1, 16'h0, 16'h0);
    run_single("prefill", 24'h000800, 400, 1, 14, 9, -1, 16'h0, 16'h0);
    run_single("wrap", 24'h0008FC, 300, 1, 14, 9, 6, 16'd402, 16'd403);

    foreach (tbl[k]) begin
      raddr   = tbl[k].addr;
      raddr_v = tbl[k].ld;
      rd_req  = tbl[k].rd;
      step();
      check($sformatf("rb%0d_data", k), rdata, tbl[k].data);
      check($sformatf("rb%0d_valid", k), rdata_v, tbl[k].v);
    end
    raddr_v = 1'b0; rd_req = 1'b0;

    // FIFO overflow: 16 real commands plus a 17th that must be dropped. The
    // 17th would rewrite 0x10.. and show up in region 1.
    for (int j = 0; j < 16; j++) push({8'(j + 1), 8'd10, 8'(j * 16)});
    push(24'h000810);
    check("ovf_full_bit", status[3], 1);
    check("ovf_sticky_bit", status[4], 1);
    check("ovf_count", status[15:8], 8'h10);
    check("ovf_status", status, 16'h101A);

    run_multi("multi", -1, dones);
    for (int c = 0; c < 20; c++) begin
      step();
      if (done) dones++;
    end
    check("multi_done_count", dones, 1);
    check("multi_end_status", status, 16'h0006);
    read_regions("multi", 16);

    // Reset in the middle of command 5 (valid sample 100 lies in 95..140).
    for (int j = 0; j < 16; j++) push({8'(j + 1), 8'd10, 8'(j * 16)});
    run_multi("abort", 100, dones);
    #1 rst_n = 1'b0;
    #1;
    check("abort_rst_status", status, 16'h0004);
    check("abort_rst_rdata", rdata, 16'h0000);
    check("abort_rst_rdata_v", rdata_v, 0);
    check("abort_rst_done", done, 0);
    #3 rst_n = 1'b1;
    repeat (3) step();
    check("abort_idle_status", status, 16'h0004);
    read_regions("abort", 4);

    // go with an empty queue goes straight to DONE; held go does not retrigger.
    go = 1'b1;
    step();
    check("empty_go_done", done, 1);
    check("empty_go_status", status, 16'h0006);
    step();
    check("empty_go_held_done", done, 0);
    go = 1'b0;
    repeat (2) step();
    check("empty_go_idle_status", status, 16'h0006);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
